// File: rtl/coefficient_bank.sv
// rtl/coefficient_bank.sv - four-entry FIR coefficient bank with modwait handshake
module coefficient_bank #(
    parameter int DATA_WIDTH  = 16,
    parameter int LOAD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  load_coeff,
    input  logic [1:0]            coefficient_num,
    input  logic                  clear_coefficient,
    input  logic [DATA_WIDTH-1:0] fir_coefficient_in,
    output logic                  modwait,
    output logic [DATA_WIDTH-1:0] coeff0,
    output logic [DATA_WIDTH-1:0] coeff1,
    output logic [DATA_WIDTH-1:0] coeff2,
    output logic [DATA_WIDTH-1:0] coeff3,
    output logic                  coeff_set_valid,
    output logic                  load_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] BUSY_INIT = 4'(LOAD_CYCLES - 1);

    state_t                r_state;
    logic [3:0]            r_counter;
    logic [3:0]            r_mask;
    logic [DATA_WIDTH-1:0] r_coeff [4];
    logic                  r_modwait;
    logic                  r_valid;
    logic                  r_err;

    logic                  w_accept;
    logic [3:0]            w_sel;
    logic [3:0]            w_mask_eff;

    assign w_accept   = load_coeff && (r_state == IDLE);
    assign w_sel      = 4'b0001 << coefficient_num;
    // A write landing on the same edge as a clear still counts toward the set
    assign w_mask_eff = r_mask | (w_accept ? w_sel : 4'b0000);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state   <= IDLE;
            r_counter <= 4'd0;
            r_mask    <= 4'b0000;
            r_modwait <= 1'b0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_coeff[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (load_coeff) begin
                        r_coeff[coefficient_num] <= fir_coefficient_in;
                        r_mask                   <= r_mask | w_sel;
                        r_valid                  <= 1'b0;
                        r_counter                <= BUSY_INIT;
                        r_modwait                <= 1'b1;
                        r_state                  <= BUSY;
                    end
                end
                BUSY: begin
                    if (load_coeff) begin
                        r_err <= 1'b1;
                    end
                    if (r_counter == 4'd0) begin
                        r_modwait <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_counter <= r_counter - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Clear is evaluated last so it overrides the load's valid de-assert
            if (clear_coefficient) begin
                r_mask <= 4'b0000;
                if (w_mask_eff == 4'b1111) begin
                    r_valid <= 1'b1;
                end else begin
                    r_valid <= 1'b0;
                    r_err   <= 1'b1;
                end
            end
        end
    end

    assign modwait         = r_modwait;
    assign coeff0          = r_coeff[0];
    assign coeff1          = r_coeff[1];
    assign coeff2          = r_coeff[2];
    assign coeff3          = r_coeff[3];
    assign coeff_set_valid = r_valid;
    assign load_err        = r_err;

    logic w_unused;
    assign w_unused = w_accept & 1'b0;

endmodule

// File: tb/tb_coefficient_bank.sv
// tb/tb_coefficient_bank.sv - randomized and directed checks of coefficient_bank against a behavioural model
module tb_coefficient_bank;

    localparam int DW = 16;
    localparam int LC = 2;

    logic          clk = 1'b0;
    logic          n_reset = 1'b0;
    logic          load_coeff = 1'b0;
    logic [1:0]    coefficient_num = 2'd0;
    logic          clear_coefficient = 1'b0;
    logic [DW-1:0] fir_coefficient_in = '0;
    logic          modwait;
    logic [DW-1:0] coeff0, coeff1, coeff2, coeff3;
    logic          coeff_set_valid;
    logic          load_err;

    coefficient_bank #(.DATA_WIDTH(DW), .LOAD_CYCLES(LC)) dut (
        .clk               (clk),
        .n_reset           (n_reset),
        .load_coeff        (load_coeff),
        .coefficient_num   (coefficient_num),
        .clear_coefficient (clear_coefficient),
        .fir_coefficient_in(fir_coefficient_in),
        .modwait           (modwait),
        .coeff0            (coeff0),
        .coeff1            (coeff1),
        .coeff2            (coeff2),
        .coeff3            (coeff3),
        .coeff_set_valid   (coeff_set_valid),
        .load_err          (load_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Behavioural model: busy time left, which indices were loaded, stored words
    int          m_busy = 0;
    bit          m_loaded [4] = '{0, 0, 0, 0};
    logic [DW-1:0] m_coeff [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
    bit          m_valid = 0;
    bit          m_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            m_busy = 0;
            m_valid = 0;
            m_err = 0;
            for (int i = 0; i < 4; i++) begin
                m_loaded[i] = 0;
                m_coeff[i] = '0;
            end
        end else begin
            if (m_busy > 0) begin
                if (load_coeff) m_err = 1;
                m_busy = m_busy - 1;
            end else if (load_coeff) begin
                m_coeff[coefficient_num] = fir_coefficient_in;
                m_loaded[coefficient_num] = 1;
                m_valid = 0;
                m_busy = LC;
            end
            if (clear_coefficient) begin
                if (m_loaded[0] && m_loaded[1] && m_loaded[2] && m_loaded[3]) begin
                    m_valid = 1;
                end else begin
                    m_valid = 0;
                    m_err = 1;
                end
                for (int i = 0; i < 4; i++) m_loaded[i] = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model modwait", 32'(modwait), 32'(m_busy > 0));
            check("model coeff0", 32'(coeff0), 32'(m_coeff[0]));
            check("model coeff1", 32'(coeff1), 32'(m_coeff[1]));
            check("model coeff2", 32'(coeff2), 32'(m_coeff[2]));
            check("model coeff3", 32'(coeff3), 32'(m_coeff[3]));
            check("model valid", 32'(coeff_set_valid), 32'(m_valid));
            check("model err", 32'(load_err), 32'(m_err));
        end
    end

    // Called at a negedge; leaves at the first negedge with modwait low
    task automatic do_load(input int idx, input logic [DW-1:0] d, output int hi);
        int n;
        load_coeff = 1'b1;
        coefficient_num = 2'(idx);
        fir_coefficient_in = d;
        @(negedge clk);
        load_coeff = 1'b0;
        hi = 0;
        n = 0;
        while (modwait && n < 20) begin
            hi++;
            n++;
            @(negedge clk);
        end
        if (modwait) check("modwait timeout", 32'(modwait), 32'd0);
    endtask

    task automatic do_clear();
        clear_coefficient = 1'b1;
        @(negedge clk);
        clear_coefficient = 1'b0;
    endtask

    task automatic do_reset();
        #2 n_reset = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic full_set(input logic [DW-1:0] base);
        int hi;
        for (int i = 0; i < 4; i++) begin
            do_load(i, base + DW'(i), hi);
            check("busy cycles", 32'(hi), 32'(LC));
        end
        do_clear();
        check("set valid", 32'(coeff_set_valid), 32'd1);
    endtask

    initial begin
        int hi;
        int t0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        chk_en = 1'b1;
        check("reset modwait", 32'(modwait), 32'd0);
        check("reset coeff0", 32'(coeff0), 32'd0);
        check("reset valid", 32'(coeff_set_valid), 32'd0);
        check("reset err", 32'(load_err), 32'd0);

        // Full set 1..4 and the 13-cycle latency
        t0 = cyc;
        full_set(16'h0001);
        check("set latency", 32'(cyc - t0), 32'd13);
        check("set coeff0", 32'(coeff0), 32'h0001);
        check("set coeff1", 32'(coeff1), 32'h0002);
        check("set coeff2", 32'(coeff2), 32'h0003);
        check("set coeff3", 32'(coeff3), 32'h0004);
        check("set err", 32'(load_err), 32'd0);

        // Reload after a closed set drops valid
        do_load(2, 16'h1234, hi);
        check("reload valid", 32'(coeff_set_valid), 32'd0);
        check("reload coeff2", 32'(coeff2), 32'h1234);

        // Incomplete set
        do_reset();
        for (int i = 0; i < 3; i++) do_load(i, 16'h00A0 + 16'(i), hi);
        do_clear();
        check("partial valid", 32'(coeff_set_valid), 32'd0);
        check("partial err", 32'(load_err), 32'd1);
        do_load(3, 16'h00A3, hi);
        do_clear();
        check("mask cleared", 32'(coeff_set_valid), 32'd0);

        // Load while busy is ignored
        do_reset();
        load_coeff = 1'b1; coefficient_num = 2'd0; fir_coefficient_in = 16'h0055;
        @(negedge clk);
        coefficient_num = 2'd3; fir_coefficient_in = 16'hBEEF;
        @(negedge clk);
        load_coeff = 1'b0;
        check("busy coeff3", 32'(coeff3), 32'd0);
        check("busy err", 32'(load_err), 32'd1);
        check("busy modwait hi", 32'(modwait), 32'd1);
        @(negedge clk);
        check("busy modwait lo", 32'(modwait), 32'd0);

        // Last load and clear on the same edge
        do_reset();
        for (int i = 0; i < 3; i++) do_load(i, 16'h0100 + 16'(i), hi);
        load_coeff = 1'b1; coefficient_num = 2'd3; fir_coefficient_in = 16'h0103;
        clear_coefficient = 1'b1;
        @(negedge clk);
        load_coeff = 1'b0; clear_coefficient = 1'b0;
        check("same-edge valid", 32'(coeff_set_valid), 32'd1);
        check("same-edge err", 32'(load_err), 32'd0);
        check("same-edge coeff3", 32'(coeff3), 32'h0103);
        repeat (LC) @(negedge clk);

        // Async reset inside the busy window of the third load
        do_load(0, 16'h0201, hi);
        do_load(1, 16'h0202, hi);
        load_coeff = 1'b1; coefficient_num = 2'd2; fir_coefficient_in = 16'h0203;
        @(negedge clk);
        load_coeff = 1'b0;
        #2 n_reset = 1'b0;
        #1;
        check("areset modwait", 32'(modwait), 32'd0);
        check("areset coeff0", 32'(coeff0), 32'd0);
        check("areset coeff1", 32'(coeff1), 32'd0);
        check("areset coeff2", 32'(coeff2), 32'd0);
        check("areset coeff3", 32'(coeff3), 32'd0);
        check("areset valid", 32'(coeff_set_valid), 32'd0);
        check("areset err", 32'(load_err), 32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        full_set(16'h0301);
        check("post-reset coeff3", 32'(coeff3), 32'h0304);

        // Random traffic, including loads while busy and occasional resets
        for (int i = 0; i < 3000; i++) begin
            load_coeff = ($urandom_range(0, 9) < 4);
            coefficient_num = 2'($urandom_range(0, 3));
            fir_coefficient_in = DW'($urandom);
            clear_coefficient = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 249) == 0) begin
                #3 n_reset = 1'b0;
            end
            @(negedge clk);
            n_reset = 1'b1;
        end
        load_coeff = 1'b0;
        clear_coefficient = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
